// File: rtl/loop_ctrl_pkg.sv
// Shared types and helpers for the LOOP control dead-time sequencer.
package loop_ctrl_pkg;

  localparam int DT_W_DEF   = 6;
  localparam int MIN_ON_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DT_TO_HS = 3'd1,
    ST_DT_TO_LS = 3'd2,
    ST_HS_ON    = 3'd3,
    ST_LS_ON    = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // A programmed dead time of zero still yields one both-off cycle.
  function automatic logic [DT_W_DEF-1:0] sat_min1(input logic [DT_W_DEF-1:0] dt);
    return (dt == '0) ? DT_W_DEF'(1) : dt;
  endfunction

endpackage

// File: rtl/loop_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PWM command into CELCLK.
module loop_ctrl_sync2 (
  input  logic CELCLK,
  input  logic CELRSTN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/loop_ctrl_deadtime_seq.sv
// Complementary high/low-side drive sequencer with dead time, enable gating and latched fault.
// Optional minimum on-time hold is compiled in with `define LOOPCTRL_MIN_ON_EN.
module loop_ctrl_deadtime_seq
  import loop_ctrl_pkg::*;
#(
  parameter int DT_W       = DT_W_DEF,
  parameter int DT_DEFAULT = 4,
  parameter int MIN_ON     = MIN_ON_DEF
) (
  input  logic            CELCLK,
  input  logic            CELRSTN,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            cfg_load,
  input  logic            fault_in,
  output logic            hs_drv,
  output logic            ls_drv,
  output logic            busy,
  output logic            fault_flag
);

  localparam logic [DT_W-1:0] DT_RST = DT_W'(DT_DEFAULT);

  logic            pwm_s;
  state_t          state, state_nxt;
  logic [DT_W-1:0] dt_reg;
  logic [DT_W-1:0] dt_cnt, dt_cnt_nxt;
  logic [DT_W-1:0] dt_load;
  logic            on_ok;

  loop_ctrl_sync2 u_sync (
    .CELCLK  (CELCLK),
    .CELRSTN (CELRSTN),
    .d       (pwm_in),
    .q       (pwm_s)
  );

`ifdef LOOPCTRL_MIN_ON_EN
  localparam int ON_W = $clog2(MIN_ON + 1);
  logic [ON_W-1:0] on_cnt;
  logic            on_now, on_nxt;

  assign on_now = (state == ST_HS_ON) || (state == ST_LS_ON);
  assign on_nxt = (state_nxt == ST_HS_ON) || (state_nxt == ST_LS_ON);
  assign on_ok  = (on_cnt >= ON_W'(MIN_ON));

  // on_cnt holds the number of cycles already spent in the current on state.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      on_cnt <= '0;
    end else if (on_nxt && !on_now) begin
      on_cnt <= ON_W'(1);
    end else if (on_now && !on_ok) begin
      on_cnt <= on_cnt + 1'b1;
    end
  end
`else
  // Without the minimum on-time hold a side change is always allowed.
  assign on_ok = (MIN_ON >= 0);
`endif

  assign dt_load = sat_min1(dt_reg);

  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    if (fault_in) begin
      state_nxt = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (!en) state_nxt = ST_IDLE;
    end else if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt  = pwm_s ? ST_DT_TO_HS : ST_DT_TO_LS;
          dt_cnt_nxt = dt_load;
        end
        // The side is re-decided from pwm_s at the end of the dead time.
        ST_DT_TO_HS, ST_DT_TO_LS: begin
          if (dt_cnt <= DT_W'(1)) state_nxt = pwm_s ? ST_HS_ON : ST_LS_ON;
          else                    dt_cnt_nxt = dt_cnt - 1'b1;
        end
        ST_HS_ON: begin
          if (!pwm_s && on_ok) begin
            state_nxt  = ST_DT_TO_LS;
            dt_cnt_nxt = dt_load;
          end
        end
        ST_LS_ON: begin
          if (pwm_s && on_ok) begin
            state_nxt  = ST_DT_TO_HS;
            dt_cnt_nxt = dt_load;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state      <= ST_IDLE;
      dt_reg     <= DT_RST;
      dt_cnt     <= '0;
      hs_drv     <= 1'b0;
      ls_drv     <= 1'b0;
      busy       <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      dt_cnt     <= dt_cnt_nxt;
      if (cfg_load && (state == ST_IDLE || state == ST_FAULT)) dt_reg <= dt_cfg;
      hs_drv     <= (state_nxt == ST_HS_ON);
      ls_drv     <= (state_nxt == ST_LS_ON);
      busy       <= (state_nxt != ST_IDLE);
      fault_flag <= (state_nxt == ST_FAULT);
    end
  end

endmodule
